// File: rtl/seg7_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder_pkg
// Brief    : Shared 7-segment pattern constants and decoded-value type.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_scan_decoder_pkg;

  localparam int DIGITS_DEFAULT = 4;

  // gfedcba, active-low (0 = segment lit)
  localparam logic [6:0] SEG_0     = 7'b100_0000;
  localparam logic [6:0] SEG_1     = 7'b111_1001;
  localparam logic [6:0] SEG_2     = 7'b010_0100;
  localparam logic [6:0] SEG_3     = 7'b011_0000;
  localparam logic [6:0] SEG_4     = 7'b001_1001;
  localparam logic [6:0] SEG_5     = 7'b001_0010;
  localparam logic [6:0] SEG_6     = 7'b000_0010;
  localparam logic [6:0] SEG_7     = 7'b111_1000;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b001_0000;
  localparam logic [6:0] SEG_A     = 7'b000_1000;
  localparam logic [6:0] SEG_B     = 7'b000_0011;
  localparam logic [6:0] SEG_C     = 7'b100_0110;
  localparam logic [6:0] SEG_D     = 7'b010_0001;
  localparam logic [6:0] SEG_E     = 7'b000_0110;
  localparam logic [6:0] SEG_F     = 7'b000_1110;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;

  typedef struct packed {
    logic       legal;
    logic [3:0] code;
  } seg_dec_t;

endpackage
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Brief    : Exact-match lookup of an active-low gfedcba pattern to {legal, code}.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
  import seg7_scan_decoder_pkg::*;
(
  input  logic [6:0] i_seg,
  output seg_dec_t   o_dec
);

  always_comb begin
    o_dec = '0;
    case (i_seg)
      SEG_0:     o_dec = '{legal: 1'b1, code: 4'h0};
      SEG_1:     o_dec = '{legal: 1'b1, code: 4'h1};
      SEG_2:     o_dec = '{legal: 1'b1, code: 4'h2};
      SEG_3:     o_dec = '{legal: 1'b1, code: 4'h3};
      SEG_4:     o_dec = '{legal: 1'b1, code: 4'h4};
      SEG_5:     o_dec = '{legal: 1'b1, code: 4'h5};
      SEG_6:     o_dec = '{legal: 1'b1, code: 4'h6};
      SEG_7:     o_dec = '{legal: 1'b1, code: 4'h7};
      SEG_8:     o_dec = '{legal: 1'b1, code: 4'h8};
      SEG_9:     o_dec = '{legal: 1'b1, code: 4'h9};
      SEG_A:     o_dec = '{legal: 1'b1, code: 4'hA};
      SEG_B:     o_dec = '{legal: 1'b1, code: 4'hB};
      SEG_C:     o_dec = '{legal: 1'b1, code: 4'hC};
      SEG_D:     o_dec = '{legal: 1'b1, code: 4'hD};
      SEG_E:     o_dec = '{legal: 1'b1, code: 4'hE};
      SEG_F:     o_dec = '{legal: 1'b1, code: 4'hF};
      SEG_BLANK: o_dec = '0;
      default:   o_dec = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Brief    : Readback of a multiplexed 7-segment bus with per-digit glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int DIGITS        = DIGITS_DEFAULT,
  parameter int STABLE_SCANS  = 2,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     an_in,
  input  logic                  sample_en,
  output logic [4*DIGITS-1:0]   value_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  value_update,
  output logic                  frame_done,
  output logic                  anode_err
);

  localparam int                c_cnt_w  = $clog2(STABLE_SCANS + 1);
  localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_SCANS);
  localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

  seg_dec_t            w_dec;
  logic [DIGITS-1:0]   w_an;
  logic                w_an_one;
  logic                w_an_multi;
  logic [DIGITS-1:0]   w_hit;
  logic [DIGITS-1:0]   w_match;
  logic [DIGITS-1:0]   w_commit;
  logic [DIGITS-1:0]   w_chg;
  logic [c_cnt_w-1:0]  w_cnt_nxt [DIGITS];
  logic [DIGITS-1:0]   w_seen_nxt;
  logic                w_frame;

  seg_dec_t            r_cand [DIGITS];
  logic [c_cnt_w-1:0]  r_cnt  [DIGITS];
  logic [3:0]          r_nib  [DIGITS];
  logic [DIGITS-1:0]   r_valid;
  logic [DIGITS-1:0]   r_seen;
  logic                r_update;
  logic                r_frame;
  logic                r_err;

  seg7_pattern_decode u_decode (
    .i_seg (seg_in),
    .o_dec (w_dec)
  );

  // x & (x-1) is nonzero exactly when two or more bits are set
  assign w_an       = AN_ACTIVE_LOW ? ~an_in : an_in;
  assign w_an_multi = |(w_an & (w_an - DIGITS'(1)));
  assign w_an_one   = (|w_an) && !w_an_multi;
  assign w_hit      = (sample_en && w_an_one) ? w_an : '0;

  assign w_seen_nxt = r_seen | w_hit;
  assign w_frame    = (|w_hit) && (&w_seen_nxt);

  always_comb begin
    w_match  = '0;
    w_commit = '0;
    w_chg    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_match[i]   = (w_dec == r_cand[i]);
      if (!w_match[i]) begin
        w_cnt_nxt[i] = c_one;
      end else if (r_cnt[i] != c_stable) begin
        w_cnt_nxt[i] = r_cnt[i] + c_one;
      end
      // Commit only on the sample that first reaches the threshold
      w_commit[i] = w_hit[i] && (w_cnt_nxt[i] == c_stable)
                    && !(w_match[i] && (r_cnt[i] == c_stable));
      if (w_dec.legal) begin
        w_chg[i] = w_commit[i] && (!r_valid[i] || (r_nib[i] != w_dec.code));
      end else begin
        w_chg[i] = w_commit[i] && r_valid[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_cand[i] <= '0;
        r_cnt[i]  <= '0;
        r_nib[i]  <= '0;
      end
      r_valid  <= '0;
      r_seen   <= '0;
      r_update <= 1'b0;
      r_frame  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_update <= |w_chg;
      r_frame  <= w_frame;
      r_err    <= sample_en && w_an_multi;
      if (|w_hit) begin
        r_seen <= w_frame ? '0 : w_seen_nxt;
      end
      for (int i = 0; i < DIGITS; i++) begin
        if (w_hit[i]) begin
          r_cand[i] <= w_dec;
          r_cnt[i]  <= w_cnt_nxt[i];
        end
        if (w_commit[i]) begin
          r_valid[i] <= w_dec.legal;
          if (w_dec.legal) begin
            r_nib[i] <= w_dec.code;
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_pack
    assign value_out[4*gi +: 4] = r_nib[gi];
  end

  assign digit_valid  = r_valid;
  assign value_update = r_update;
  assign frame_done   = r_frame;
  assign anode_err    = r_err;

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive side of the multiplexed 7-segment display bus.
- Samples the active-low gfedcba segment lines and the per-digit anode enables driven by the display scanner, and decodes each segment pattern back to a 4-bit hex value.
- Filters glitches by requiring repeated identical samples before accepting a value, then presents the reconstructed multi-digit value.
- Used as an on-chip display readback/monitor for self-check and for the testbench scoreboard.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_SCANS, 2, consecutive identical samples of a digit required to commit it (1..15).
- AN_ACTIVE_LOW, 1, 1 = anode enable is active-low, 0 = active-high.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines, bit6..0 = g..a, active-low (0 = segment lit).
- an_in  input  DIGITS  anode enables; polarity set by AN_ACTIVE_LOW.
- sample_en  input  1  one-cycle strobe; sample seg_in/an_in this cycle.
- value_out  output  4*DIGITS  committed hex values; digit i occupies bits [4i+3:4i].
- digit_valid  output  DIGITS  1 = digit i last committed a legal hex pattern.
- value_update  output  1  one-cycle pulse when any committed nibble or valid bit changes.
- frame_done  output  1  one-cycle pulse when every digit has been sampled since the last pulse.
- anode_err  output  1  one-cycle pulse when a sample has more than one anode active.

Behaviour:
- Reset (async, immediate):
  - value_out = 0, digit_valid = 0, value_update = 0, frame_done = 0, anode_err = 0.
  - Every per-digit candidate is invalid with count 0; the seen mask is cleared.
  - Asserting rst mid-operation discards partial counts and produces no pulses.
- Pattern decode (combinational):
  - Exact match against the 16 legal codes: 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000, A=000_1000, b=000_0011, C=100_0110, d=010_0001, E=000_0110, F=000_1110.
  - Output is {legal, code[3:0]}. Any other pattern, including blank 111_1111, gives legal = 0 and code = 0.
- Anode qualification on sample_en:
  - Normalise an_in to active-high.
  - Exactly one bit set: accepted sample for that digit index i.
  - Zero bits set: sample ignored silently.
  - Two or more bits set: sample ignored; anode_err pulses the next cycle.
  - sample_en = 0: no state change.
- Stability filter, per digit, 5-bit candidate cand[i] plus counter cnt[i] of width clog2(STABLE_SCANS+1):
  - On an accepted sample, if the decoded value equals cand[i], cnt[i] increments and saturates at STABLE_SCANS.
  - Otherwise cand[i] is set to the decoded value and cnt[i] is set to 1.
  - A commit occurs on the sample where cnt[i] first reaches STABLE_SCANS.
  - With STABLE_SCANS = 1, every sample that changes cand[i] commits.
  - Further identical samples at saturation do not re-commit.
- Commit:
  - Legal decode: nibble i = code and digit_valid[i] = 1.
  - Illegal decode: digit_valid[i] = 0 and nibble i holds its previous value.
  - value_update pulses only if the nibble or the valid bit actually changed.
- Latency: all outputs are registered and update on the clock edge that samples sample_en = 1, so they are visible the following cycle. No pulse is ever wider than one cycle.
- Frame tracking:
  - seen[i] is set on each accepted sample for digit i.
  - When the OR of seen and the current sample bit is all ones, frame_done pulses and seen clears to 0, including the current bit.
  - Repeated samples of the same digit within a frame are harmless.
- Simultaneous events: value_update, frame_done and a commit may all occur on the same edge. anode_err never coincides with the others because that sample is rejected.

Decomposition:
- Shared package:
  - Segment pattern constants SEG_0..SEG_F and SEG_BLANK, also used by the encode side.
  - Digit-count default.
  - A 5-bit decoded-value typedef {legal, code}.
- One natural sub-module: seg7_pattern_decode, a pure combinational 7-to-5 exact-match lookup, instantiated once on the shared seg_in bus.
- The anode one-hot check, per-digit filters and frame mask stay in the top module.

Test Plan:
- Sweep: STABLE_SCANS=1, digit0 fed each legal code 0..F in turn -> value_out[3:0] tracks 0..F, digit_valid[0]=1, value_update pulses 16 times; feeding 111_1111 -> digit_valid[0]=0, nibble held at F.
- Filter: STABLE_SCANS=2, digit1 sampled 011_0000, 000_0000, 011_0000 -> no commit and no value_update. Then 011_0000 once more -> value_out[7:4]=3, digit_valid[1]=1, one value_update pulse.
- Invalid commit: digit2 committed to 5, then sampled 111_1111 twice -> digit_valid[2]=0, value_out[11:8] stays 5, one value_update pulse.
- Anode error: an_in=4'b1100 (active-low, two digits on) with sample_en -> anode_err pulses one cycle; value_out, digit_valid and seen unchanged. an_in=4'b1111 -> no pulse, no change.
- Frame: samples of digits 0,1,1,2,3 -> frame_done pulses exactly once, the cycle after the digit3 sample. Resampling identical stable values -> no value_update.
- Reset mid-count: digit0 has cnt=1, then rst asserted between clock edges -> outputs clear immediately. After release, a single 010_0100 sample does not commit (STABLE_SCANS=2); a second one commits 2.
